// File: rtl/imm_gen_pkg.sv
// imm_gen_pkg
// Shared definitions for the immediate generator pipeline:
//   - RV32I/RV64I base opcode constants (instr[6:0])
//   - 3-bit immediate format code presented on out_type
//   - XLEN-independent decode result struct used by the decoder
package imm_gen_pkg;

    localparam logic [6:0] OP_LOAD     = 7'b0000011;
    localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OP_IMM      = 7'b0010011;
    localparam logic [6:0] OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] OP_IMM_32   = 7'b0011011;
    localparam logic [6:0] OP_STORE    = 7'b0100011;
    localparam logic [6:0] OP_OP       = 7'b0110011;
    localparam logic [6:0] OP_LUI      = 7'b0110111;
    localparam logic [6:0] OP_OP_32    = 7'b0111011;
    localparam logic [6:0] OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] OP_JALR     = 7'b1100111;
    localparam logic [6:0] OP_JAL      = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

    typedef enum logic [2:0] {
        FMT_R    = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_Z    = 3'd6,
        FMT_NONE = 3'd7
    } fmt_e;

    // Every RV immediate fits in 32 bits before extension; the decoder
    // builds this form first and widens it to XLEN afterwards.
    typedef struct packed {
        logic [31:0] imm32;
        fmt_e        fmt;
        logic        illegal;
    } dec_t;

endpackage

// File: rtl/imm_decode.sv
// imm_decode
// Purely combinational immediate decoder.
// Ports:
//   instr   - 32-bit instruction word
//   imm     - immediate, sign-extended (zero-extended for CSR zimm) to XLEN
//   fmt     - format code (imm_gen_pkg::fmt_e)
//   illegal - opcode not recognised for this XLEN, or instr[1:0] != 2'b11
module imm_decode
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      fmt,
    output logic            illegal
);

    localparam bit RV64 = (XLEN == 64);

    dec_t dec;

    always_comb begin
        dec.imm32   = '0;
        dec.fmt     = FMT_NONE;
        dec.illegal = 1'b0;
        case (instr[6:0])
            OP_LOAD, OP_IMM, OP_JALR, OP_MISC_MEM: begin
                dec.fmt   = FMT_I;
                dec.imm32 = {{20{instr[31]}}, instr[31:20]};
            end
            OP_STORE: begin
                dec.fmt   = FMT_S;
                dec.imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            end
            OP_BRANCH: begin
                dec.fmt   = FMT_B;
                dec.imm32 = {{19{instr[31]}}, instr[31], instr[7],
                             instr[30:25], instr[11:8], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                dec.fmt   = FMT_U;
                dec.imm32 = {instr[31:12], 12'b0};
            end
            OP_JAL: begin
                dec.fmt   = FMT_J;
                dec.imm32 = {{11{instr[31]}}, instr[31], instr[19:12],
                             instr[20], instr[30:21], 1'b0};
            end
            OP_SYSTEM: begin
                // funct3[2] selects the CSR immediate forms (csrr*i)
                if (instr[14]) begin
                    dec.fmt   = FMT_Z;
                    dec.imm32 = {27'b0, instr[19:15]};
                end else begin
                    dec.fmt   = FMT_I;
                    dec.imm32 = {{20{instr[31]}}, instr[31:20]};
                end
            end
            OP_OP: begin
                dec.fmt = FMT_R;
            end
            OP_OP_32: begin
                if (RV64) begin
                    dec.fmt = FMT_R;
                end
            end
            OP_IMM_32: begin
                if (RV64) begin
                    dec.fmt   = FMT_I;
                    dec.imm32 = {{20{instr[31]}}, instr[31:20]};
                end
            end
            default: begin
                dec.fmt = FMT_NONE;
            end
        endcase
        // Compressed-space words never match a listed opcode, but the
        // explicit low-bit test keeps the intent visible.
        dec.illegal = (dec.fmt == FMT_NONE) || (instr[1:0] != 2'b11);
    end

    assign fmt     = dec.fmt;
    assign illegal = dec.illegal;

    // imm32[31] is the sign for every format (zimm has it cleared), so a
    // plain replicate of bit 31 covers all extension cases.
    generate
        if (XLEN > 32) begin : g_wide
            assign imm = {{(XLEN-32){dec.imm32[31]}}, dec.imm32};
        end else begin : g_narrow
            assign imm = dec.imm32;
        end
    endgenerate

endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe
// Registered immediate generator with valid/ready handshake and a 2-entry
// skid buffer (main entry M drives the outputs, skid entry K absorbs the
// one instruction that arrives while the consumer stalls).
// Ports:
//   clk, rst_n           - clock, asynchronous active-low reset
//   flush                - synchronous drop of all buffered entries
//   in_valid/in_ready    - upstream handshake (in_ready registered, = !K.valid)
//   in_instr, in_tag     - instruction word and sideband tag (PC)
//   out_valid/out_ready  - downstream handshake
//   out_imm, out_type,
//   out_illegal          - decoded immediate, format code, illegal flag
//   out_instr, out_tag   - instruction and tag passed through
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_type,
    output logic             out_illegal,
    output logic [31:0]      out_instr,
    output logic [TAG_W-1:0] out_tag
);

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [2:0]       fmt;
        logic             illegal;
        logic [31:0]      instr;
        logic [TAG_W-1:0] tag;
    } entry_t;

    logic [XLEN-1:0] dec_imm;
    logic [2:0]      dec_fmt;
    logic            dec_illegal;
    entry_t          new_entry;

    entry_t m_reg;
    entry_t k_reg;
    logic   m_valid_reg;
    logic   k_valid_reg;
    logic   in_ready_reg;

    logic   m_valid_next;
    logic   k_valid_next;
    logic   m_load_new;
    logic   m_load_k;
    logic   k_load;

    logic   accept;
    logic   pop;

    // Decode once at the input so both buffer entries hold finished data.
    imm_decode #(
        .XLEN (XLEN)
    ) u_decode (
        .instr   (in_instr),
        .imm     (dec_imm),
        .fmt     (dec_fmt),
        .illegal (dec_illegal)
    );

    assign new_entry = '{imm: dec_imm, fmt: dec_fmt, illegal: dec_illegal,
                         instr: in_instr, tag: in_tag};

    assign accept = in_valid && in_ready_reg;
    assign pop    = m_valid_reg && out_ready;

    always_comb begin
        m_valid_next = m_valid_reg;
        k_valid_next = k_valid_reg;
        m_load_new   = 1'b0;
        m_load_k     = 1'b0;
        k_load       = 1'b0;
        if (flush) begin
            m_valid_next = 1'b0;
            k_valid_next = 1'b0;
        end else if (pop && k_valid_reg) begin
            // in_ready is low whenever K is full, so no accept can coincide
            m_load_k     = 1'b1;
            k_valid_next = 1'b0;
        end else if (accept && (!m_valid_reg || pop)) begin
            m_load_new   = 1'b1;
            m_valid_next = 1'b1;
        end else if (accept) begin
            k_load       = 1'b1;
            k_valid_next = 1'b1;
        end else if (pop) begin
            m_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid_reg  <= 1'b0;
            k_valid_reg  <= 1'b0;
            in_ready_reg <= 1'b1;
        end else begin
            m_valid_reg  <= m_valid_next;
            k_valid_reg  <= k_valid_next;
            in_ready_reg <= !k_valid_next;
        end
    end

    // Payload registers change only on a load; flush touches valids only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_reg <= '0;
            k_reg <= '0;
        end else begin
            if (m_load_new) begin
                m_reg <= new_entry;
            end else if (m_load_k) begin
                m_reg <= k_reg;
            end
            if (k_load) begin
                k_reg <= new_entry;
            end
        end
    end

    assign in_ready    = in_ready_reg;
    assign out_valid   = m_valid_reg;
    assign out_imm     = m_reg.imm;
    assign out_type    = m_reg.fmt;
    assign out_illegal = m_reg.illegal;
    assign out_instr   = m_reg.instr;
    assign out_tag     = m_reg.tag;

endmodule
